// File: rtl/cache_pkg.sv
// cache_ctrl shared definitions: default widths, response level codes
// and the request sequencer state encoding.
package cache_pkg;

  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 17;
  localparam int DEF_TIMEOUT = 31;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_L1   = 2'd1;
  localparam logic [1:0] LVL_L2   = 2'd2;
  localparam logic [1:0] LVL_MEM  = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    L1_RD,
    L1_CHK,
    L2_RD,
    MEM_RD,
    L2_FILL,
    L1_FILL,
    L1_WR,
    WT_L2,
    WT_MEM,
    RESP
  } state_e;

  // States that hold an L2 or memory request open until ack or timeout
  function automatic logic is_wait(state_e s);
    return (s == L2_RD)   || (s == MEM_RD) ||
           (s == L2_FILL) || (s == WT_L2)  ||
           (s == WT_MEM);
  endfunction

endpackage

// File: rtl/cache_wait_timer.sv
// Ack wait counter shared by all L2/memory wait states.
// expired is high during the TIMEOUT-th enabled cycle since clear.
module cache_wait_timer #(
  parameter int TIMEOUT = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

  // Count wait cycles; restart whenever the FSM changes state
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Request sequencer for L1 / L2 / memory with write-through stores.
// Optional CACHE_CTRL_STATS_EN adds saturating 8-bit event counters.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [1:0]        resp_level,
  output logic              resp_err,
  output logic [ADDR_W-1:0] l1_addr,
  output logic              l1_wren,
  output logic [DATA_W-1:0] l1_data,
  input  logic              l1_hit,
  input  logic [DATA_W-1:0] l1_q,
  output logic              l2_req,
  output logic              l2_wren,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic              l2_ack,
  input  logic              l2_hit,
  input  logic [DATA_W-1:0] l2_rdata,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [7:0]        stat_l1_hits,
  output logic [7:0]        stat_l2_hits,
  output logic [7:0]        stat_mem_reads,
  output logic [7:0]        stat_errs
`endif
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        level_q, level_d;
  logic              err_q, err_d;

  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;

  assign tmr_en    = is_wait(state_q);
  assign tmr_clear = (state_d != state_q);

  cache_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  // Next state, latched request/fill word and port outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    level_d    = level_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_level = LVL_NONE;
    resp_err   = 1'b0;
    l1_addr    = '0;
    l1_wren    = 1'b0;
    l1_data    = '0;
    l2_req     = 1'b0;
    l2_wren    = 1'b0;
    l2_addr    = '0;
    l2_wdata   = '0;
    mem_req    = 1'b0;
    mem_wren   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          level_d = LVL_NONE;
          err_d   = 1'b0;
          state_d = req_wren ? L1_WR : L1_RD;
        end
      end
      L1_RD: begin
        l1_addr = addr_q;
        state_d = L1_CHK;
      end
      L1_CHK: begin
        if (l1_hit) begin
          data_d  = l1_q;
          level_d = LVL_L1;
          state_d = RESP;
        end else begin
          state_d = L2_RD;
        end
      end
      L2_RD: begin
        l2_req  = 1'b1;
        l2_addr = addr_q;
        if (l2_ack) begin
          if (l2_hit) begin
            data_d  = l2_rdata;
            level_d = LVL_L2;
            state_d = L1_FILL;
          end else begin
            state_d = MEM_RD;
          end
        end else if (tmr_expired) begin
          data_d  = '0;
          level_d = LVL_NONE;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          data_d  = mem_rdata;
          level_d = LVL_MEM;
          state_d = L2_FILL;
        end else if (tmr_expired) begin
          data_d  = '0;
          level_d = LVL_NONE;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      L2_FILL: begin
        l2_req   = 1'b1;
        l2_wren  = 1'b1;
        l2_addr  = addr_q;
        l2_wdata = data_q;
        if (l2_ack) begin
          state_d = L1_FILL;
        end else if (tmr_expired) begin
          data_d  = '0;
          level_d = LVL_NONE;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      L1_FILL: begin
        l1_wren = 1'b1;
        l1_addr = addr_q;
        l1_data = data_q;
        state_d = RESP;
      end
      L1_WR: begin
        l1_wren = 1'b1;
        l1_addr = addr_q;
        l1_data = data_q;
        state_d = WT_L2;
      end
      WT_L2: begin
        l2_req   = 1'b1;
        l2_wren  = 1'b1;
        l2_addr  = addr_q;
        l2_wdata = data_q;
        if (l2_ack) begin
          state_d = WT_MEM;
        end else if (tmr_expired) begin
          data_d  = '0;
          level_d = LVL_NONE;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WT_MEM: begin
        mem_req   = 1'b1;
        mem_wren  = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        if (mem_ack) begin
          level_d = LVL_NONE;
          state_d = RESP;
        end else if (tmr_expired) begin
          data_d  = '0;
          level_d = LVL_NONE;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = data_q;
        resp_level = level_q;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      level_q <= LVL_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [7:0] l1h_q, l1h_d;
  logic [7:0] l2h_q, l2h_d;
  logic [7:0] mrd_q, mrd_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       in_resp;

  assign in_resp        = (state_q == RESP);
  assign stat_l1_hits   = l1h_q;
  assign stat_l2_hits   = l2h_q;
  assign stat_mem_reads = mrd_q;
  assign stat_errs      = err_cnt_q;

  // Saturating event counters bumped once per response
  always_comb begin
    l1h_d     = l1h_q;
    l2h_d     = l2h_q;
    mrd_d     = mrd_q;
    err_cnt_d = err_cnt_q;
    if (in_resp) begin
      if (err_q) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        if (level_q == LVL_L1 && l1h_q != 8'hFF) l1h_d = l1h_q + 8'd1;
        if (level_q == LVL_L2 && l2h_q != 8'hFF) l2h_d = l2h_q + 8'd1;
        if (level_q == LVL_MEM && mrd_q != 8'hFF) mrd_d = mrd_q + 8'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      l1h_q     <= '0;
      l2h_q     <= '0;
      mrd_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      l1h_q     <= l1h_d;
      l2h_q     <= l2h_d;
      mrd_q     <= mrd_d;
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with L1/L2/memory responder models
// and a response scoreboard checked with immediate assertions.
module tb_cache_ctrl;

  localparam int AW = 7;
  localparam int DW = 17;
  localparam int TO = 31;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_wren;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic [1:0]    resp_level;
  logic          resp_err;
  logic [AW-1:0] l1_addr;
  logic          l1_wren;
  logic [DW-1:0] l1_data;
  logic          l1_hit;
  logic [DW-1:0] l1_q;
  logic          l2_req, l2_wren;
  logic [AW-1:0] l2_addr;
  logic [DW-1:0] l2_wdata;
  logic          l2_ack = 1'b0;
  logic          l2_hit;
  logic [DW-1:0] l2_rdata;
  logic          mem_req, mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
  logic [7:0] stat_l1_hits, stat_l2_hits;
  logic [7:0] stat_mem_reads, stat_errs;
`endif

  always #5 clk = ~clk;

  cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wren(req_wren), .req_addr(req_addr),
    .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_level(resp_level), .resp_err(resp_err),
    .l1_addr(l1_addr), .l1_wren(l1_wren),
    .l1_data(l1_data), .l1_hit(l1_hit), .l1_q(l1_q),
    .l2_req(l2_req), .l2_wren(l2_wren),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_ack(l2_ack), .l2_hit(l2_hit),
    .l2_rdata(l2_rdata),
    .mem_req(mem_req), .mem_wren(mem_wren),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .stat_l1_hits(stat_l1_hits),
    .stat_l2_hits(stat_l2_hits),
    .stat_mem_reads(stat_mem_reads),
    .stat_errs(stat_errs)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    level;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int fails   = 0;
  int cyc = 0, acc_cyc = 0, resp_cnt = 0;
  int l1w_n, l2w_n, l2r_n, memr_n, memw_n;
  int l1w_cyc, l2w_cyc, memw_cyc;
  logic [DW-1:0] l1w_data, l2w_data, memw_data;

  int l2_lat = 1, mem_lat = 1;
  bit l2_en = 1, mem_en = 1;
  int l2_cnt = 0, mem_cnt = 0;

  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] l1_mem [128];
  bit            l1_vld [128];

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // L1 model: hit/q registered one edge after the address
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) l1_vld[i] <= 1'b0;
    end else begin
      if (pre_en) begin
        l1_mem[pre_addr] <= pre_data;
        l1_vld[pre_addr] <= 1'b1;
      end
      if (l1_wren) begin
        l1_mem[l1_addr] <= l1_data;
        l1_vld[l1_addr] <= 1'b1;
      end
    end
    l1_hit <= l1_vld[l1_addr];
    l1_q   <= l1_mem[l1_addr];
  end

  // L2 / memory responders: ack in the (lat+1)-th request cycle
  always @(negedge clk) begin
    if (!l2_req) begin
      l2_cnt = 0;
      l2_ack = 1'b0;
    end else if (!l2_ack && l2_en) begin
      l2_cnt++;
      if (l2_cnt > l2_lat) l2_ack = 1'b1;
    end
    if (!mem_req) begin
      mem_cnt = 0;
      mem_ack = 1'b0;
    end else if (!mem_ack && mem_en) begin
      mem_cnt++;
      if (mem_cnt > mem_lat) mem_ack = 1'b1;
    end
  end

  // Monitor: port activity and scoreboard compare on responses
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (req_valid && req_ready) acc_cyc = cyc;
    if (l1_wren) begin
      l1w_n++;
      l1w_data = l1_data;
      l1w_cyc  = cyc;
    end
    if (l2_req && l2_wren) begin
      if (l2w_n == 0) l2w_cyc = cyc;
      l2w_n++;
      l2w_data = l2_wdata;
    end
    if (l2_req && !l2_wren) l2r_n++;
    if (mem_req && !mem_wren) memr_n++;
    if (mem_req && mem_wren) begin
      if (memw_n == 0) memw_cyc = cyc;
      memw_n++;
      memw_data = mem_wdata;
    end
    if (resp_valid) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        check("spurious_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_data", 32'(resp_data), 32'(e.data));
        check("resp_level", 32'(resp_level), 32'(e.level));
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
      end
    end
  end

  task automatic clr_cnt();
    l1w_n = 0; l2w_n = 0; l2r_n = 0;
    memr_n = 0; memw_n = 0;
    l1w_cyc = 0; l2w_cyc = 0; memw_cyc = 0;
  endtask

  task automatic preload(logic [AW-1:0] a, logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(posedge clk); #1;
    pre_en   = 1'b0;
  endtask

  task automatic send(logic w, logic [AW-1:0] a,
                      logic [DW-1:0] d);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check("req_ready_wait", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_wren  = w;
    req_addr  = a;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic txn(logic w, logic [AW-1:0] a,
                     logic [DW-1:0] d);
    int start;
    int n;
    start = resp_cnt;
    send(w, a, d);
    n = 0;
    while (resp_cnt == start && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (resp_cnt == start) check("resp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic expect_resp(logic [DW-1:0] d, logic [1:0] lv,
                             logic er, int lat);
    exp_t e;
    e.data  = d;
    e.level = lv;
    e.err   = er;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  initial begin
    int n;
    int rc;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_wren  = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    l2_hit    = 1'b0;
    l2_rdata  = '0;
    mem_rdata = '0;
    clr_cnt();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_l1_wren", 32'(l1_wren), 32'd0);
    check("rst_l2_req", 32'(l2_req), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // L1 read hit
    preload(7'h15, 17'h05A5A);
    clr_cnt();
    expect_resp(17'h05A5A, 2'd1, 1'b0, 3);
    txn(1'b0, 7'h15, '0);
    check("hit_no_l2", 32'(l2r_n), 32'd0);
    check("hit_no_mem", 32'(memr_n), 32'd0);

    // L1 miss, L2 hit, then re-read hits L1
    clr_cnt();
    l2_hit   = 1'b1;
    l2_rdata = 17'h0ABCD;
    l2_lat   = 1;
    expect_resp(17'h0ABCD, 2'd2, 1'b0, 6);
    txn(1'b0, 7'h22, '0);
    check("l2hit_l1_fills", 32'(l1w_n), 32'd1);
    check("l2hit_fill_data", 32'(l1w_data), 32'h0ABCD);
    check("l2hit_no_mem", 32'(memr_n), 32'd0);
    clr_cnt();
    expect_resp(17'h0ABCD, 2'd1, 1'b0, 3);
    txn(1'b0, 7'h22, '0);

    // L1 and L2 miss, memory read with 4-cycle ack
    clr_cnt();
    l2_hit    = 1'b0;
    mem_lat   = 4;
    mem_rdata = 17'h1FFFF;
    expect_resp(17'h1FFFF, 2'd3, 1'b0, 13);
    txn(1'b0, 7'h2A, '0);
    check("mem_l2_fill_seen", 32'(l2w_n > 0), 32'd1);
    check("mem_l2_fill_data", 32'(l2w_data), 32'h1FFFF);
    check("mem_l1_fills", 32'(l1w_n), 32'd1);
    check("mem_l1_fill_data", 32'(l1w_data), 32'h1FFFF);
`ifdef CACHE_CTRL_STATS_EN
    check("stat_l1_hits", 32'(stat_l1_hits), 32'd2);
    check("stat_l2_hits", 32'(stat_l2_hits), 32'd1);
    check("stat_mem_reads", 32'(stat_mem_reads), 32'd1);
`endif

    // Write-through store
    clr_cnt();
    mem_lat = 1;
    expect_resp(17'h00123, 2'd0, 1'b0, 6);
    txn(1'b1, 7'h40, 17'h00123);
    check("wr_l1_pulses", 32'(l1w_n), 32'd1);
    check("wr_l1_data", 32'(l1w_data), 32'h00123);
    check("wr_l2_data", 32'(l2w_data), 32'h00123);
    check("wr_mem_data", 32'(memw_data), 32'h00123);
    check("wr_order_l1_l2", 32'(l1w_cyc < l2w_cyc), 32'd1);
    check("wr_order_l2_mem", 32'(l2w_cyc < memw_cyc), 32'd1);

    // Memory never acks: timeout error, no fills
    clr_cnt();
    mem_en = 0;
    expect_resp('0, 2'd0, 1'b1, 3 + 2 + TO);
    txn(1'b0, 7'h33, '0);
    check("to_mem_req_cycles", 32'(memr_n), 32'(TO));
    check("to_no_l1_fill", 32'(l1w_n), 32'd0);
    check("to_no_l2_fill", 32'(l2w_n), 32'd0);
`ifdef CACHE_CTRL_STATS_EN
    check("stat_errs", 32'(stat_errs), 32'd1);
`endif
    mem_en = 1;

    // Reset while waiting in L2_RD abandons the request
    l2_en = 0;
    send(1'b0, 7'h50, '0);
    n = 0;
    while (!l2_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mid_l2_req_seen", 32'(l2_req), 32'd1);
    rc = resp_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_l2_req", 32'(l2_req), 32'd0);
    reset = 1'b0;
    l2_en = 1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_no_resp", 32'(resp_cnt - rc), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
